// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data cache memory arbiter.
//   BLOCK_WORDS : default burst length in words
//   WORD_BYTES  : default bytes per memory word
//   t_arb_state : arbiter FSM encoding
package mem_arbiter_pkg;

  localparam int BLOCK_WORDS = 16;
  localparam int WORD_BYTES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IC_XFER = 2'd1,
    ST_DC_XFER = 2'd2,
    ST_DONE    = 2'd3
  } t_arb_state;

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// Beat counter for one burst.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : force the count to 0 (start of a new burst)
//   i_inc        : a beat completed this cycle
//   o_cnt        : current beat index
//   o_last       : current beat is the final one of the block
module burst_counter #(
  parameter int BLOCK_WORDS = 16,
  parameter int CNT_W       = $clog2(BLOCK_WORDS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_last = (cnt_q == CNT_W'(BLOCK_WORDS - 1));
  assign o_cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)      cnt_d = '0;
    else if (i_inc) cnt_d = o_last ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an I-cache fill port and a D-cache fill/write-back
// port share one beat-oriented memory port. A grant covers a whole block
// burst; simultaneous requests alternate via a last-grant flag.
//   i_clk, i_rst                     : clock, synchronous active-high reset
//   i_ic_* / o_ic_*                  : I-cache fill request and handshakes
//   i_dc_* / o_dc_*                  : D-cache fill/write-back request
//   o_rdata, o_word_idx              : shared read word and beat index
//   o_mem_* / i_mem_*                : memory beat interface
module mem_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = mem_arbiter_pkg::BLOCK_WORDS
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_ic_req,
  input  logic [ADDR_W-1:0]              i_ic_addr,
  output logic                           o_ic_valid,
  output logic                           o_ic_done,
  input  logic                           i_dc_req,
  input  logic                           i_dc_we,
  input  logic [ADDR_W-1:0]              i_dc_addr,
  input  logic [DATA_W-1:0]              i_dc_wdata,
  output logic                           o_dc_valid,
  output logic                           o_dc_done,
  output logic [DATA_W-1:0]              o_rdata,
  output logic [$clog2(BLOCK_WORDS)-1:0] o_word_idx,
  output logic                           o_mem_req,
  output logic                           o_mem_we,
  output logic [ADDR_W-1:0]              o_mem_addr,
  output logic [DATA_W-1:0]              o_mem_wdata,
  input  logic                           i_mem_ready,
  input  logic [DATA_W-1:0]              i_mem_rdata
);

  import mem_arbiter_pkg::*;

  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam int WB    = DATA_W / 8;
  localparam int WB_SH = $clog2(WB);
  localparam int OFF_W = $clog2(BLOCK_WORDS * WB);
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF_W;

  t_arb_state        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic              dc_gnt_q, dc_gnt_d;     // current owner: 1 = DC
  logic              last_dc_q, last_dc_d;   // previous owner: 1 = DC
  logic              pick_dc;
  logic              in_xfer, beat, start;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;

  assign in_xfer = (state_q == ST_IC_XFER) || (state_q == ST_DC_XFER);
  assign start   = (state_q == ST_IDLE) && (i_ic_req || i_dc_req);
  assign beat    = in_xfer && i_mem_ready && !i_rst;

  burst_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (start),
    .i_inc  (beat),
    .o_cnt  (cnt),
    .o_last (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    we_d      = we_q;
    dc_gnt_d  = dc_gnt_q;
    last_dc_d = last_dc_q;
    // On a tie the side that did not own the previous burst wins.
    pick_dc   = (i_ic_req && i_dc_req) ? !last_dc_q : i_dc_req;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = pick_dc ? ST_DC_XFER : ST_IC_XFER;
          dc_gnt_d = pick_dc;
          we_d     = pick_dc && i_dc_we;
          base_d   = (pick_dc ? i_dc_addr : i_ic_addr) & BASE_MASK;
        end
      end
      ST_IC_XFER, ST_DC_XFER: begin
        // Requests are not looked at here, so a dropped req is ignored.
        if (beat && cnt_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        last_dc_d = dc_gnt_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      we_q      <= 1'b0;
      dc_gnt_q  <= 1'b0;
      last_dc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      we_q      <= we_d;
      dc_gnt_q  <= dc_gnt_d;
      last_dc_q <= last_dc_d;
    end
  end

  // Outputs decode registered state; reset blanks them in the same cycle.
  assign o_mem_req   = in_xfer && !i_rst;
  assign o_mem_we    = o_mem_req && we_q;
  assign o_mem_addr  = o_mem_req ? base_q + (ADDR_W'(cnt) << WB_SH) : '0;
  assign o_mem_wdata = o_mem_req ? i_dc_wdata : '0;
  assign o_rdata     = beat ? i_mem_rdata : '0;
  assign o_ic_valid  = beat && !dc_gnt_q;
  assign o_dc_valid  = beat && dc_gnt_q;
  assign o_ic_done   = (state_q == ST_DONE) && !dc_gnt_q && !i_rst;
  assign o_dc_done   = (state_q == ST_DONE) && dc_gnt_q && !i_rst;
  assign o_word_idx  = i_rst ? '0 : cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_ic_req = 1'b0;
  logic [63:0] i_ic_addr = '0;
  logic        o_ic_valid, o_ic_done;
  logic        i_dc_req = 1'b0;
  logic        i_dc_we = 1'b0;
  logic [63:0] i_dc_addr = '0;
  logic [31:0] i_dc_wdata;
  logic        o_dc_valid, o_dc_done;
  logic [31:0] o_rdata;
  logic [3:0]  o_word_idx;
  logic        o_mem_req, o_mem_we;
  logic [63:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ready = 1'b1;
  logic [31:0] i_mem_rdata;

  always #5 i_clk = ~i_clk;

  // Memory returns a value derived from the address; the D-cache supplies a
  // write word derived from the beat index it is asked for.
  assign i_mem_rdata = o_mem_addr[31:0] ^ 32'hDEADBEEF;
  assign i_dc_wdata  = 32'hC0DE0000 | {28'd0, o_word_idx};

  mem_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ic_req(i_ic_req), .i_ic_addr(i_ic_addr),
    .o_ic_valid(o_ic_valid), .o_ic_done(o_ic_done),
    .i_dc_req(i_dc_req), .i_dc_we(i_dc_we), .i_dc_addr(i_dc_addr),
    .i_dc_wdata(i_dc_wdata), .o_dc_valid(o_dc_valid), .o_dc_done(o_dc_done),
    .o_rdata(o_rdata), .o_word_idx(o_word_idx),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  idx;
    logic        dc;
    logic        we;
  } beat_t;

  beat_t sb[$];
  beat_t e;
  int total = 0;
  int bad = 0;
  logic rdy_toggle = 1'b0;
  int drop_beat = -1;

  task automatic push_burst(input logic dc, input logic we, input logic [63:0] addr);
    beat_t b;
    for (int i = 0; i < 16; i++) begin
      b.addr = (addr & ~64'h3F) + 64'(i * 4);
      b.idx  = 4'(i);
      b.dc   = dc;
      b.we   = we;
      sb.push_back(b);
    end
  endtask

  // Scoreboard: every completed beat is popped and checked.
  always @(negedge i_clk) begin
    if (!i_rst && o_mem_req && i_mem_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got addr=%h idx=%0d, required no beat", o_mem_addr, o_word_idx);
      end else begin
        e = sb.pop_front();
        if (o_mem_addr !== e.addr || o_word_idx !== e.idx || o_mem_we !== e.we ||
            o_mem_wdata !== (32'hC0DE0000 | {28'd0, e.idx}) ||
            o_rdata !== (e.addr[31:0] ^ 32'hDEADBEEF) ||
            o_dc_valid !== e.dc || o_ic_valid !== !e.dc) begin
          bad++;
          $display("FAIL beat: got addr=%h idx=%0d we=%b wd=%h rd=%h icv=%b dcv=%b, required addr=%h idx=%0d we=%b dc=%b",
                   o_mem_addr, o_word_idx, o_mem_we, o_mem_wdata, o_rdata, o_ic_valid, o_dc_valid,
                   e.addr, e.idx, e.we, e.dc);
        end
      end
    end else if (o_ic_valid || o_dc_valid) begin
      total++;
      bad++;
      $display("FAIL valid_without_beat: got icv=%b dcv=%b, required 0", o_ic_valid, o_dc_valid);
    end
  end

  task automatic apply_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1; i_ic_req = 1'b0; i_dc_req = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  // Observes one burst; cycle 1 is the cycle in which it is called.
  task automatic run_burst(input int max_c, output int done_c, output int first_c,
                           output int nvi, output int nvd, output int ndi, output int ndd,
                           output int nreq, output int nwe, output logic post);
    logic drop_now;
    done_c = -1; first_c = -1; nvi = 0; nvd = 0; ndi = 0; ndd = 0;
    nreq = 0; nwe = 0; post = 1'b0; drop_now = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      i_mem_ready = rdy_toggle ? (c % 2 == 1) : 1'b1;
      @(negedge i_clk);
      if (o_mem_req && first_c < 0) first_c = c;
      nreq += int'(o_mem_req);
      nwe  += int'(o_mem_req && o_mem_we);
      nvi  += int'(o_ic_valid);
      nvd  += int'(o_dc_valid);
      ndi  += int'(o_ic_done);
      ndd  += int'(o_dc_done);
      if (drop_beat >= 0 && o_ic_valid && o_word_idx == 4'(drop_beat)) drop_now = 1'b1;
      if (o_ic_done || o_dc_done) begin
        done_c = c;
        break;
      end
      @(posedge i_clk); #1;
      if (drop_now) i_ic_req = 1'b0;
    end
    if (done_c > 0) begin
      @(posedge i_clk); #1;
      i_ic_req = 1'b0; i_dc_req = 1'b0; i_mem_ready = 1'b1;
      @(negedge i_clk);
      post = o_ic_done | o_dc_done | o_mem_req;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_ic_req = 1'b1; i_dc_req = 1'b1;
    @(negedge i_clk);
    total++;
    if ({o_ic_valid, o_ic_done, o_dc_valid, o_dc_done, o_mem_req, o_mem_we} !== 6'b0 ||
        o_mem_addr !== 64'd0 || o_mem_wdata !== 32'd0 || o_rdata !== 32'd0 || o_word_idx !== 4'd0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b addr=%h idx=%0d, required all zero", o_mem_req, o_mem_addr, o_word_idx);
    end
    i_ic_req = 1'b0; i_dc_req = 1'b0;
    apply_reset();
    @(negedge i_clk);
    total++;
    if (o_mem_req !== 1'b0 || o_word_idx !== 4'd0) begin
      bad++;
      $display("FAIL reset_idle: got req=%b idx=%0d, required 0 0", o_mem_req, o_word_idx);
    end
  endtask

  task automatic test_ic_fill();
    int dc_, fc, nvi, nvd, ndi, ndd, nreq, nwe;
    logic post;
    @(posedge i_clk); #1;
    i_ic_addr = 64'h1044; i_ic_req = 1'b1;
    push_burst(1'b0, 1'b0, 64'h1044);
    run_burst(60, dc_, fc, nvi, nvd, ndi, ndd, nreq, nwe, post);
    total++;
    if (dc_ !== 18) begin bad++; $display("FAIL ic_done_cycle: got %0d, required 18", dc_); end
    total++;
    if (nvi !== 16 || nvd !== 0 || ndi !== 1 || ndd !== 0) begin
      bad++; $display("FAIL ic_counts: got icv=%0d dcv=%0d icd=%0d dcd=%0d, required 16 0 1 0", nvi, nvd, ndi, ndd);
    end
    total++;
    if (fc !== 2 || post !== 1'b0) begin
      bad++; $display("FAIL ic_latency: got first_req=%0d post=%b, required 2 0", fc, post);
    end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL ic_sb_empty: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_simultaneous();
    int dc_, fc, nvi, nvd, ndi, ndd, nreq, nwe;
    logic post;
    apply_reset();
    i_ic_addr = 64'h5000; i_dc_addr = 64'h6010; i_dc_we = 1'b0;
    i_ic_req = 1'b1; i_dc_req = 1'b1;
    push_burst(1'b1, 1'b0, 64'h6010);
    run_burst(60, dc_, fc, nvi, nvd, ndi, ndd, nreq, nwe, post);
    total++;
    if (ndd !== 1 || ndi !== 0 || nvd !== 16 || nvi !== 0) begin
      bad++; $display("FAIL tie_first_dc: got dcd=%0d icd=%0d dcv=%0d icv=%0d, required 1 0 16 0", ndd, ndi, nvd, nvi);
    end
    i_ic_req = 1'b1; i_dc_req = 1'b1;
    push_burst(1'b0, 1'b0, 64'h5000);
    run_burst(60, dc_, fc, nvi, nvd, ndi, ndd, nreq, nwe, post);
    total++;
    if (ndi !== 1 || ndd !== 0 || nvi !== 16 || nvd !== 0) begin
      bad++; $display("FAIL tie_second_ic: got icd=%0d dcd=%0d icv=%0d dcv=%0d, required 1 0 16 0", ndi, ndd, nvi, nvd);
    end
  endtask

  task automatic test_dc_writeback();
    int dc_, fc, nvi, nvd, ndi, ndd, nreq, nwe;
    logic post;
    @(posedge i_clk); #1;
    i_dc_addr = 64'h2000; i_dc_we = 1'b1; i_dc_req = 1'b1;
    push_burst(1'b1, 1'b1, 64'h2000);
    rdy_toggle = 1'b1;
    run_burst(80, dc_, fc, nvi, nvd, ndi, ndd, nreq, nwe, post);
    rdy_toggle = 1'b0; i_dc_we = 1'b0;
    total++;
    if (dc_ !== 34) begin bad++; $display("FAIL wb_done_cycle: got %0d, required 34", dc_); end
    total++;
    if (nreq !== 32 || nwe !== 32) begin
      bad++; $display("FAIL wb_we_throughout: got req_cycles=%0d we_cycles=%0d, required 32 32", nreq, nwe);
    end
    total++;
    if (nvd !== 16 || ndd !== 1 || nvi !== 0) begin
      bad++; $display("FAIL wb_counts: got dcv=%0d dcd=%0d icv=%0d, required 16 1 0", nvd, ndd, nvi);
    end
  endtask

  task automatic test_reset_abort();
    logic found;
    int ndone;
    found = 1'b0;
    @(posedge i_clk); #1;
    i_dc_addr = 64'h3000; i_dc_we = 1'b0; i_dc_req = 1'b1;
    push_burst(1'b1, 1'b0, 64'h3000);
    for (int c = 0; c < 30; c++) begin
      @(negedge i_clk);
      if (o_dc_valid && o_word_idx == 4'd6) begin found = 1'b1; break; end
      @(posedge i_clk); #1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL abort_reach_beat6: got timeout, required beat 6"); end
    // Reset lands on the cycle that would carry beat 7.
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    total++;
    if (o_mem_req !== 1'b0 || o_dc_valid !== 1'b0) begin
      bad++; $display("FAIL abort_rst_cycle: got req=%b dcv=%b, required 0 0", o_mem_req, o_dc_valid);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_dc_req = 1'b0;
    @(negedge i_clk);
    total++;
    if (o_mem_req !== 1'b0 || o_dc_done !== 1'b0 || o_word_idx !== 4'd0) begin
      bad++; $display("FAIL abort_idle: got req=%b done=%b idx=%0d, required 0 0 0", o_mem_req, o_dc_done, o_word_idx);
    end
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      ndone += int'(o_dc_done | o_mem_req);
    end
    total++;
    if (ndone !== 0) begin bad++; $display("FAIL abort_no_done: got %0d active cycles, required 0", ndone); end
    sb.delete();
  endtask

  task automatic test_ic_drop();
    int dc_, fc, nvi, nvd, ndi, ndd, nreq, nwe;
    logic post;
    @(posedge i_clk); #1;
    i_ic_addr = 64'h7ABC; i_ic_req = 1'b1;
    push_burst(1'b0, 1'b0, 64'h7ABC);
    drop_beat = 3;
    run_burst(60, dc_, fc, nvi, nvd, ndi, ndd, nreq, nwe, post);
    drop_beat = -1;
    total++;
    if (nvi !== 16 || ndi !== 1 || dc_ !== 18 || post !== 1'b0) begin
      bad++; $display("FAIL ic_drop: got icv=%0d icd=%0d done_cycle=%0d post=%b, required 16 1 18 0", nvi, ndi, dc_, post);
    end
  endtask

  task automatic test_back_to_back();
    int dc_, fc, nvi, nvd, ndi, ndd, nreq, nwe;
    logic post;
    @(posedge i_clk); #1;
    i_dc_addr = 64'h8000; i_dc_we = 1'b0; i_dc_req = 1'b1;
    push_burst(1'b1, 1'b0, 64'h8000);
    run_burst(60, dc_, fc, nvi, nvd, ndi, ndd, nreq, nwe, post);
    total++;
    if (ndd !== 1 || post !== 1'b0) begin
      bad++; $display("FAIL b2b_first: got dcd=%0d post=%b, required 1 0", ndd, post);
    end
    // Still in the cycle after done: re-request. Cycle 1 of the next run is
    // two cycles after done.
    i_dc_addr = 64'h8040; i_dc_req = 1'b1;
    push_burst(1'b1, 1'b0, 64'h8040);
    run_burst(60, dc_, fc, nvi, nvd, ndi, ndd, nreq, nwe, post);
    total++;
    if (fc !== 1 || ndd !== 1 || nvd !== 16 || dc_ !== 17) begin
      bad++; $display("FAIL b2b_second: got first_req=%0d dcd=%0d dcv=%0d done=%0d, required 1 1 16 17", fc, ndd, nvd, dc_);
    end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL b2b_sb_empty: got %0d left, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_ic_fill();
    test_simultaneous();
    test_dc_writeback();
    test_reset_abort();
    test_ic_drop();
    test_back_to_back();
    repeat (2) @(posedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, required completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have a single clock, i_clk, and a synchronous active-high reset, i_rst, sampled on the rising edge of i_clk.
REQ-002 Parameters SHALL be:
  - ADDR_W, default 64, address width.
  - DATA_W, default 32, memory word width.
  - BLOCK_WORDS, default 16, burst length in words (power of two, at least 2).
REQ-003 Clock and reset SHALL be:
  - i_clk  in  1  clock.
  - i_rst  in  1  synchronous active-high reset.
REQ-004 Instruction-cache port SHALL be (block fill, read only):
  - i_ic_req  in  1  fill request, held until done.
  - i_ic_addr  in  ADDR_W  miss address.
  - o_ic_valid  out  1  read word valid.
  - o_ic_done  out  1  fill complete pulse.
REQ-005 Data-cache port SHALL be:
  - i_dc_req  in  1  request, held until done.
  - i_dc_we  in  1  1 = write-back, 0 = fill.
  - i_dc_addr  in  ADDR_W  address.
  - i_dc_wdata  in  DATA_W  write word for the current o_word_idx.
  - o_dc_valid  out  1  word transferred.
  - o_dc_done  out  1  transfer complete pulse.
REQ-006 Shared outputs SHALL be:
  - o_rdata  out  DATA_W  read word, forwarded from memory.
  - o_word_idx  out  log2(BLOCK_WORDS)  index of the current beat.
REQ-007 Memory port SHALL be:
  - o_mem_req  out  1  beat request.
  - o_mem_we  out  1  write beat.
  - o_mem_addr  out  ADDR_W  word address.
  - o_mem_wdata  out  DATA_W  write word.
  - i_mem_ready  in  1  beat accepted.
  - i_mem_rdata  in  DATA_W  read data, valid when ready.

Function
REQ-008 The FSM SHALL have the states IDLE, IC_XFER, DC_XFER and DONE.
REQ-009 IDLE transitions:
  - Only i_ic_req: next state IC_XFER.
  - Only i_dc_req: next state DC_XFER.
  - Both: the grant SHALL go to the requester not granted last (last_grant flag), which gives DC first after reset.
  - Neither: stay in IDLE.
REQ-010 On leaving IDLE, the block SHALL latch the block base address as the request address with its low log2(BLOCK_WORDS*DATA_W/8) bits cleared, latch i_dc_we, and clear the beat counter.
REQ-011 In an XFER state, o_mem_req SHALL be 1 and o_mem_addr SHALL equal base + counter*(DATA_W/8).
REQ-012 In an XFER state, o_mem_we SHALL be the latched we (0 for IC) and o_mem_wdata SHALL be i_dc_wdata.
REQ-013 A beat completes in a cycle where o_mem_req=1 and i_mem_ready=1; in that cycle the block SHALL:
  - pulse the granted o_*_valid;
  - drive o_rdata = i_mem_rdata combinationally;
  - increment the counter at the clock edge.
REQ-014 i_mem_ready=0 SHALL hold the counter, the address and the state (wait states are unbounded).
REQ-015 The beat at counter = BLOCK_WORDS-1 SHALL move the FSM to DONE, and the counter SHALL wrap to 0.
REQ-016 In DONE, the granted o_*_done SHALL be 1 for exactly one cycle, o_mem_req SHALL be 0, and last_grant SHALL update; the next state is IDLE.
REQ-017 The granted requester dropping its request mid-burst SHALL be ignored; the burst completes.
REQ-018 Requests SHALL NOT be sampled in XFER or DONE; a requester SHALL deassert its req in the cycle after its done.
REQ-019 Minimum latency SHALL be: request to first o_mem_req is 1 cycle; last beat to done is 1 cycle; a burst takes BLOCK_WORDS+2 cycles at zero wait.
REQ-020 o_word_idx SHALL equal the counter in every state.
REQ-021 All ungranted valid and done outputs SHALL be 0.

Reset
REQ-022 When i_rst=1, the block SHALL force:
  - state IDLE, counter 0, last_grant = IC;
  - all o_* outputs 0.
REQ-023 Reset SHALL abort any burst in progress; no done pulse SHALL be produced for the aborted burst.

Structure
REQ-024 A shared package SHALL hold the state enum (t_arb_state) and the constants BLOCK_WORDS and WORD_BYTES.
REQ-025 The beat counter with its wrap and last-beat flag SHALL be one sub-module, burst_counter; all other logic SHALL be in mem_arbiter.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
  - IC-only fill, i_ic_addr=0x1044, ready always 1: addresses 0x1040..0x107C in steps of 4, 16 o_ic_valid pulses, o_ic_done in cycle 18.
  - Simultaneous IC and DC requests after reset: DC is served first; the next simultaneous request is served to IC.
  - DC write-back at 0x2000 with ready toggling 1,0: o_mem_we=1 throughout, each wdata is sampled per o_word_idx, and the burst takes 32 beat cycles plus 2.
  - i_rst asserted at beat 7 of a DC fill: the next cycle is IDLE with o_mem_req=0, no o_dc_done, and the counter at 0.
  - IC drops i_ic_req at beat 3: all 16 beats still complete and o_ic_done pulses once.
  - Back-to-back: DC re-requests in the cycle after its done while IC is idle: the new burst starts with first o_mem_req 2 cycles after the done.
